// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: word/mask widths and the FSM state enum.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Instruction fetches always read the full word.
  localparam lc3b_mem_wmask FETCH_WMASK = 2'b11;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory port.
// Handshake: a requester raises read/write with stable attributes and holds
// them until its single-cycle resp strobe; the memory side answers a pmem
// strobe with a single-cycle pmem_resp carrying pmem_rdata in the same cycle.
interface cache_arbiter_if;
  import lc3b_types::*;

  logic          ifetch_read;
  lc3b_word      ifetch_address;
  lc3b_word      ifetch_rdata;
  logic          ifetch_resp;

  logic          mem_read;
  logic          mem_write;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  // Arbiter view.
  modport slave (
    input  ifetch_read, ifetch_address,
    output ifetch_rdata, ifetch_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    input  pmem_rdata, pmem_resp
  );

  // Environment view (requesters plus memory).
  modport master (
    output ifetch_read, ifetch_address,
    input  ifetch_rdata, ifetch_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_arbiter_grant.sv
// Next-grant decision for the arbiter. Fixed data priority by default;
// with ARBITER_RR_EN defined a tie goes to the requester not served last.
module arb_grant (
  input  logic i_ifetch_req,
  input  logic i_mem_req,
`ifdef ARBITER_RR_EN
  input  logic i_last_was_d,
`endif
  output logic o_grant_i,
  output logic o_grant_d
);

  // Pick at most one winner among the active requesters.
  always_comb begin
    o_grant_i = 1'b0;
    o_grant_d = 1'b0;
`ifdef ARBITER_RR_EN
    if (i_ifetch_req && i_mem_req) begin
      o_grant_d = ~i_last_was_d;
      o_grant_i = i_last_was_d;
    end else begin
      o_grant_d = i_mem_req;
      o_grant_i = i_ifetch_req;
    end
`else
    o_grant_d = i_mem_req;
    o_grant_i = i_ifetch_req & ~i_mem_req;
`endif
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time. Build option: ARBITER_RR_EN (alternate tie winner).
module cache_arbiter
  import lc3b_types::*;
(
  input  logic            clk,
  input  logic            reset_n,
  cache_arbiter_if.slave  bus,
  output arb_state_t      o_dbg_state
);

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  lc3b_word      r_address;
  lc3b_word      r_wdata;
  lc3b_mem_wmask r_byte_enable;
  logic          r_write;
  logic          w_mem_req;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_resp_i;
  logic          w_resp_d;

  assign w_mem_req = bus.mem_read | bus.mem_write;

`ifdef ARBITER_RR_EN
  logic r_last_was_d;

  arb_grant u_grant (
    .i_ifetch_req (bus.ifetch_read),
    .i_mem_req    (w_mem_req),
    .i_last_was_d (r_last_was_d),
    .o_grant_i    (w_grant_i),
    .o_grant_d    (w_grant_d)
  );

  // Remember who won the most recent grant; reset points at fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_was_d <= 1'b0;
    end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
      r_last_was_d <= w_grant_d;
    end
  end
`else
  arb_grant u_grant (
    .i_ifetch_req (bus.ifetch_read),
    .i_mem_req    (w_mem_req),
    .o_grant_i    (w_grant_i),
    .o_grant_d    (w_grant_d)
  );
`endif

  // State register plus the transaction attributes captured on the grant edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_address     <= '0;
      r_wdata       <= '0;
      r_byte_enable <= '0;
      r_write       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (w_grant_d) begin
          r_address     <= bus.mem_address;
          r_wdata       <= bus.mem_wdata;
          r_byte_enable <= bus.mem_byte_enable;
          r_write       <= bus.mem_write;
        end else if (w_grant_i) begin
          r_address     <= bus.ifetch_address;
          r_wdata       <= '0;
          r_byte_enable <= FETCH_WMASK;
          r_write       <= 1'b0;
        end
      end
    end
  end

  // Next state and completion strobes; pmem_resp only matters while serving.
  always_comb begin
    w_next_state = r_state;
    w_resp_i     = 1'b0;
    w_resp_d     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next_state = SERVE_D;
        else if (w_grant_i) w_next_state = SERVE_I;
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          w_resp_i     = 1'b1;
          w_next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          w_resp_d     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The shared port is driven only from the captured registers.
  assign bus.pmem_read        = (r_state != IDLE) & ~r_write;
  assign bus.pmem_write       = (r_state != IDLE) &  r_write;
  assign bus.pmem_address     = r_address;
  assign bus.pmem_wdata       = r_wdata;
  assign bus.pmem_byte_enable = r_byte_enable;

  assign bus.ifetch_resp  = w_resp_i;
  assign bus.mem_resp     = w_resp_d;
  assign bus.ifetch_rdata = bus.pmem_rdata;
  assign bus.mem_rdata    = bus.pmem_rdata;

  assign o_dbg_state = r_state;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
 clk  in  1  rising-edge clock
 reset_n  in  1  synchronous active-low reset
 ifetch_read  in  1  instruction-fetch read request
 ifetch_address  in  16  fetch address
 ifetch_rdata  out  16  fetch read data
 ifetch_resp  out  1  fetch completion strobe
 mem_read  in  1  data read request
 mem_write  in  1  data write request
 mem_address  in  16  data address
 mem_wdata  in  16  data write data
 mem_byte_enable  in  2  data byte enables
 mem_rdata  out  16  data read data
 mem_resp  out  1  data completion strobe
 pmem_read  out  1  shared-port read strobe
 pmem_write  out  1  shared-port write strobe
 pmem_address  out  16  shared-port address
 pmem_wdata  out  16  shared-port write data
 pmem_byte_enable  out  2  shared-port byte enables
 pmem_rdata  in  16  shared-port read data
 pmem_resp  in  1  shared-port completion strobe

Function
REQ-003 The block SHALL share one memory port between the fetch and data requesters, one transaction at a time.
REQ-004 FSM states SHALL be IDLE, SERVE_I and SERVE_D.
REQ-005 IDLE transitions:
 - only ifetch_read -> SERVE_I
 - only mem_read or mem_write -> SERVE_D
 - both requesters active -> winner per REQ-011
 - neither active -> stay in IDLE
REQ-006 On the grant edge, the block SHALL latch address, wdata, byte_enable and read/write type into registers; pmem_* SHALL be driven only from those registers.
REQ-007 Latency: a request seen in IDLE at edge t SHALL produce pmem_read or pmem_write high from t+1 until the cycle pmem_resp is seen, inclusive.
REQ-008 In SERVE_x with pmem_resp=1, the block SHALL pulse x_resp high for exactly that cycle, pass pmem_rdata through combinationally to x_rdata, and return to IDLE at the next edge.
REQ-009 Outside REQ-008, ifetch_resp and mem_resp SHALL be 0; the non-granted requester SHALL never see resp.
REQ-010 Requesters SHALL hold their request and attributes stable until their resp; changes during service SHALL be ignored.
REQ-011 Arbitration default: data wins simultaneous requests (fixed priority).
REQ-012 mem_read and mem_write together SHALL be treated as a write.
REQ-013 Every transaction SHALL include at least one IDLE cycle between transactions, with pmem_read=pmem_write=0 in IDLE.
REQ-014 pmem_resp in IDLE SHALL be ignored.

Reset
REQ-015 With reset_n=0 at an edge, the block SHALL enter IDLE and clear all latched registers to 0.
REQ-016 pmem_read, pmem_write, ifetch_resp and mem_resp SHALL be 0 from the following cycle.
REQ-017 Reset mid-transaction SHALL abandon the transaction with no resp to either requester; a later pmem_resp SHALL be ignored per REQ-014.

Configuration
REQ-018 Macro ARBITER_RR_EN:
 - Defined: simultaneous requests SHALL be granted to the requester not served in the most recent grant; the last-served flag resets to fetch, so the first tie goes to data.
 - Undefined: fixed data priority per REQ-011, and no last-served register is present.

Structure
REQ-019 The state enum (arb_state_t: IDLE, SERVE_I, SERVE_D) SHALL live in package lc3b_types; widths SHALL use lc3b_word.
REQ-020 The next-grant decision, including the ARBITER_RR_EN variant, SHALL be isolated in one combinational sub-module, arb_grant.

Verification
REQ-021 Fetch only: ifetch_read=1 at address 16'h0040, pmem_resp after 3 cycles with rdata 16'h1234 -> pmem_address=16'h0040, ifetch_rdata=16'h1234, single-cycle ifetch_resp, mem_resp=0.
REQ-022 Data write: address 16'h0100, wdata 16'hBEEF, byte_enable 2'b10 -> pmem_write=1 with those exact values, single-cycle mem_resp.
REQ-023 Tie, macro undefined: both requests in the same cycle -> data served first, one IDLE cycle, then fetch; two responses total.
REQ-024 Tie, ARBITER_RR_EN defined, three consecutive ties -> grant order D, I, D.
REQ-025 reset_n=0 during SERVE_D, then a pmem_resp pulse -> no mem_resp, state IDLE, pmem strobes 0.
REQ-026 Address changed to 16'hFFFF mid-service -> pmem_address keeps the latched value until resp.
